// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: instruction encodings, ROB entry layout and pointer helper.
package tomasulo_pkg;

  localparam int ROB_DEPTH_DEF = 8;
  localparam int TAG_W_DEF     = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int REG_W_DEF     = 5;
  localparam int TYPE_W_DEF    = 3;

  localparam logic [TYPE_W_DEF-1:0] T_LOAD = 3'b001;
  localparam logic [TYPE_W_DEF-1:0] T_ADD  = 3'b010;
  localparam logic [TYPE_W_DEF-1:0] T_SUB  = 3'b011;
  localparam logic [TYPE_W_DEF-1:0] T_MUL  = 3'b100;
  localparam logic [TYPE_W_DEF-1:0] T_DIV  = 3'b101;

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_ISSUED = 2'd1,
    E_DONE   = 2'd2
  } ent_st_e;

  typedef struct packed {
    ent_st_e                st;
    logic [TYPE_W_DEF-1:0]  typ;
    logic [REG_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0]  val;
  } rob_entry_t;

  // Circular pointer advance, shared with decode so both ends wrap identically.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p + 1 >= depth) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer: allocation from decode, CDB result capture by tag, in-order retirement.
// Entry widths follow the package defaults, so DATA_W/REG_W/TYPE_W should not be overridden.
module rob_commit
  import tomasulo_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int TYPE_W    = TYPE_W_DEF
) (
  input  logic                           clk1,
  input  logic                           rst_n,
  input  logic                           alloc_valid,
  input  logic [TYPE_W-1:0]              alloc_type,
  input  logic [REG_W-1:0]               alloc_rd,
  output logic                           alloc_ready,
  output logic [TAG_W-1:0]               alloc_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_value,
  output logic                           commit_valid,
  input  logic                           commit_ready,
  output logic [TAG_W-1:0]               commit_tag,
  output logic [TYPE_W-1:0]              commit_type,
  output logic [REG_W-1:0]               commit_rd,
  output logic [DATA_W-1:0]              commit_value,
  output logic [$clog2(ROB_DEPTH+1)-1:0] rob_count,
  output logic                           cdb_err
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(ROB_DEPTH+1);

  rob_entry_t       r_ent [ROB_DEPTH];
  logic [IDX_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_cdb_err;

  logic             w_alloc, w_commit;
  logic             w_cdb_in_rng, w_cdb_hit, w_cdb_bad;
  logic [IDX_W-1:0] w_cdb_idx;
  rob_entry_t       w_head;

  assign w_head       = r_ent[r_head];
  assign alloc_ready  = (r_count != CNT_W'(ROB_DEPTH));
  assign alloc_tag    = TAG_W'(r_tail) + TAG_W'(1);
  assign commit_valid = (w_head.st == E_DONE);
  assign w_alloc      = alloc_valid && alloc_ready;
  assign w_commit     = commit_valid && commit_ready;

  // Tag 0 means "value in ARF" and is silently dropped; any other miss is an error.
  assign w_cdb_in_rng = (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_DEPTH));
  assign w_cdb_idx    = IDX_W'(cdb_tag - TAG_W'(1));
  assign w_cdb_hit    = cdb_valid && w_cdb_in_rng && (r_ent[w_cdb_idx].st == E_ISSUED);
  assign w_cdb_bad    = cdb_valid && (cdb_tag != '0) && !w_cdb_hit;

  assign rob_count = r_count;
  assign cdb_err   = r_cdb_err;

  // Head fields are presented only while the head is retireable; otherwise zero.
  always_comb begin
    commit_tag   = '0;
    commit_type  = '0;
    commit_rd    = '0;
    commit_value = '0;
    if (commit_valid) begin
      commit_tag   = TAG_W'(r_head) + TAG_W'(1);
      commit_type  = w_head.typ;
      commit_rd    = w_head.rd;
      commit_value = w_head.val;
    end
  end

  // Entry array: commit, allocate and CDB always target distinct entries (DONE/FREE/ISSUED).
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
    end else begin
      if (w_commit) r_ent[r_head].st <= E_FREE;
      if (w_alloc)  r_ent[r_tail] <= '{st: E_ISSUED, typ: alloc_type, rd: alloc_rd, val: '0};
      if (w_cdb_hit) begin
        r_ent[w_cdb_idx].st  <= E_DONE;
        r_ent[w_cdb_idx].val <= cdb_value;
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) r_head <= IDX_W'(wrap_inc(32'(r_head), ROB_DEPTH));
      if (w_alloc)  r_tail <= IDX_W'(wrap_inc(32'(r_tail), ROB_DEPTH));
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky illegal-CDB flag; only reset clears it.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)         r_cdb_err <= 1'b0;
    else if (w_cdb_bad) r_cdb_err <= 1'b1;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: fill/full, ordering, stall, wrap, error flag, concurrency.
module tb_rob_commit;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [2:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        commit_valid;
  logic        commit_ready;
  logic [3:0]  commit_tag;
  logic [2:0]  commit_type;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  rob_count;
  logic        cdb_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk1 = ~clk1;

  rob_commit dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_type(commit_type), .commit_rd(commit_rd),
    .commit_value(commit_value), .rob_count(rob_count), .cdb_err(cdb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_type = 0; alloc_rd = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    commit_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic alloc1(input logic [2:0] ty, input logic [4:0] rd, input logic [3:0] exp_tag);
    alloc_valid = 1; alloc_type = ty; alloc_rd = rd;
    chk("alloc_tag", alloc_tag, exp_tag);
    chk("alloc_rdy", alloc_ready, 1);
    tick();
    alloc_valid = 0;
  endtask

  task automatic cdb1(input logic [3:0] t, input logic [31:0] v);
    cdb_valid = 1; cdb_tag = t; cdb_value = v;
    tick();
    cdb_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();

    // reset state
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 1);
    chk("rst_cv", commit_valid, 0);
    chk("rst_ctag", commit_tag, 0);
    chk("rst_cval", commit_value, 0);
    chk("rst_cnt", rob_count, 0);
    chk("rst_err", cdb_err, 0);

    // fill: ADD rd 3..10 -> tags 1..8
    for (int i = 0; i < 8; i++) alloc1(3'b010, 5'(i + 3), 4'(i + 1));
    chk("full_cnt", rob_count, 8);
    chk("full_rdy", alloc_ready, 0);
    chk("full_tag", alloc_tag, 1);
    chk("full_cv", commit_valid, 0);
    alloc_valid = 1; alloc_type = 3'b010; alloc_rd = 5'd11;
    tick();
    alloc_valid = 0;
    chk("ninth_cnt", rob_count, 8);
    chk("ninth_rdy", alloc_ready, 0);

    // mid-operation reset discards everything
    do_reset();
    chk("rrst_cnt", rob_count, 0);
    chk("rrst_rdy", alloc_ready, 1);
    chk("rrst_tag", alloc_tag, 1);
    tick();

    // out-of-order completion, in-order retirement
    alloc1(3'b010, 5'd1, 1);
    alloc1(3'b011, 5'd2, 2);
    cdb1(2, 32'h55);
    chk("ooo_cv0", commit_valid, 0);
    chk("ooo_ctag0", commit_tag, 0);
    cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h11;
    chk("ooo_nobyp", commit_valid, 0);
    tick();
    cdb_valid = 0;
    commit_ready = 1;
    chk("ooo_cv1", commit_valid, 1);
    chk("ooo_tag1", commit_tag, 1);
    chk("ooo_val1", commit_value, 32'h11);
    chk("ooo_typ1", commit_type, 3'b010);
    chk("ooo_rd1", commit_rd, 1);
    tick();
    chk("ooo_tag2", commit_tag, 2);
    chk("ooo_val2", commit_value, 32'h55);
    chk("ooo_typ2", commit_type, 3'b011);
    chk("ooo_cnt1", rob_count, 1);
    tick();
    commit_ready = 0;
    chk("ooo_cv_e", commit_valid, 0);
    chk("ooo_cnt0", rob_count, 0);
    chk("ooo_etag", alloc_tag, 3);

    // stall with head DONE
    alloc1(3'b100, 5'd7, 3);
    cdb1(3, 32'hABCD);
    for (int i = 0; i < 3; i++) begin
      chk("stl_cv", commit_valid, 1);
      chk("stl_tag", commit_tag, 3);
      chk("stl_val", commit_value, 32'hABCD);
      chk("stl_rd", commit_rd, 7);
      chk("stl_cnt", rob_count, 1);
      tick();
    end
    commit_ready = 1;
    tick();
    commit_ready = 0;
    chk("stl_cnt0", rob_count, 0);
    chk("stl_cv0", commit_valid, 0);
    chk("stl_atag", alloc_tag, 4);

    // full with head DONE, commit + refused alloc, then wrap
    do_reset();
    tick();
    for (int i = 0; i < 8; i++) alloc1(3'b001, 5'(i), 4'(i + 1));
    cdb1(1, 32'hA1);
    cdb1(2, 32'hA2);
    cdb1(3, 32'hA3);
    chk("fw_cv", commit_valid, 1);
    chk("fw_tag", commit_tag, 1);
    alloc_valid = 1; alloc_type = 3'b101; alloc_rd = 5'd20;
    commit_ready = 1;
    chk("fw_rdy0", alloc_ready, 0);
    tick();
    alloc_valid = 0;
    chk("fw_cnt7", rob_count, 7);
    chk("fw_rdy1", alloc_ready, 1);
    chk("fw_tag2", commit_tag, 2);
    chk("fw_atag", alloc_tag, 1);
    tick();
    tick();
    commit_ready = 0;
    chk("fw_cnt5", rob_count, 5);
    chk("fw_cv0", commit_valid, 0);
    alloc1(3'b010, 5'd1, 1);
    alloc1(3'b010, 5'd2, 2);
    alloc1(3'b010, 5'd3, 3);
    chk("wr_cnt", rob_count, 8);
    chk("wr_atag", alloc_tag, 4);
    chk("wr_rdy", alloc_ready, 0);

    // alloc, CDB and commit in one cycle
    do_reset();
    tick();
    alloc1(3'b001, 5'd4, 1);
    alloc1(3'b101, 5'd0, 2);
    cdb1(1, 32'h77);
    alloc_valid = 1; alloc_type = 3'b010; alloc_rd = 5'd9;
    cdb_valid = 1; cdb_tag = 2; cdb_value = 32'h99;
    commit_ready = 1;
    chk("tri_tag1", commit_tag, 1);
    tick();
    idle_inputs();
    chk("tri_cnt", rob_count, 2);
    chk("tri_cv", commit_valid, 1);
    chk("tri_tag", commit_tag, 2);
    chk("tri_val", commit_value, 32'h99);
    chk("tri_rd0", commit_rd, 0);
    chk("tri_err", cdb_err, 0);
    chk("tri_atag", alloc_tag, 4);
    // CDB to the entry being allocated this cycle is illegal
    alloc_valid = 1; alloc_type = 3'b011; alloc_rd = 5'd5;
    cdb_valid = 1; cdb_tag = 4; cdb_value = 32'h44;
    tick();
    idle_inputs();
    chk("sa_err", cdb_err, 1);
    chk("sa_cnt", rob_count, 3);

    // illegal CDB writes
    do_reset();
    tick();
    chk("er_rst", cdb_err, 0);
    cdb1(0, 32'h1);
    chk("er_tag0", cdb_err, 0);
    cdb1(5, 32'h5);
    chk("er_free", cdb_err, 1);
    chk("er_cnt", rob_count, 0);
    chk("er_cv", commit_valid, 0);
    do_reset();
    chk("er_clr", cdb_err, 0);
    tick();
    cdb1(12, 32'hC);
    chk("er_rng", cdb_err, 1);
    tick(); tick(); tick();
    chk("er_hold", cdb_err, 1);
    do_reset();
    chk("er_clr2", cdb_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer storage and in-order retirement for the Tomasulo core.
- Decode allocates one entry per issued instruction and receives its destination tag.
- The common data bus (CDB) writes results into entries by tag.
- The head entry retires to the architectural register file / RAT once its result is present, strictly in program order.

This is the consuming end of the ROB allocation interface driven by the decode/issue stage.

## Interface
Parameters:
- ROB_DEPTH, 8: number of entries; tags run 1..ROB_DEPTH.
- TAG_W, 4: tag width; tag 0 is reserved as "no tag / value in ARF".
- DATA_W, 32: result width.
- REG_W, 5: architectural register index width.
- TYPE_W, 3: instruction type width (LOAD 001, ADD 010, SUB 011, MUL 100, DIV 101).

Ports:
- clk1  in  1  clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- alloc_valid  in  1  decode requests an entry.
- alloc_type  in  TYPE_W  instruction type.
- alloc_rd  in  REG_W  destination register.
- alloc_ready  out  1  an entry is free.
- alloc_tag  out  TAG_W  tag the next allocation receives; equals tail+1.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  producing entry.
- cdb_value  in  DATA_W  result.
- commit_valid  out  1  head entry is ready to retire.
- commit_ready  in  1  ARF/RAT accepts the retirement.
- commit_tag  out  TAG_W  head tag.
- commit_type  out  TYPE_W  head type.
- commit_rd  out  REG_W  head destination register.
- commit_value  out  DATA_W  head result.
- rob_count  out  $clog2(ROB_DEPTH+1)  occupied entries.
- cdb_err  out  1  sticky flag; set by an illegal CDB write.

## Operation
Per-entry state:
- FREE -> ISSUED on allocation.
- ISSUED -> DONE on a CDB tag match; the value is latched.
- DONE -> FREE on commit.

Each entry stores the state, type, rd and value.

Pointers:
- head and tail run 0..ROB_DEPTH-1 and wrap to 0.
- tag = index+1.

Allocation:
- Fires when alloc_valid && alloc_ready.
- Writes entry[tail] with type and rd, clears its value, sets state ISSUED, and increments tail.
- When alloc_valid is low or the ROB is full, the allocation inputs are ignored.

CDB write:
- Applies when cdb_valid and cdb_tag is in 1..ROB_DEPTH with the entry ISSUED: latch cdb_value, set state DONE.
- A CDB write to tag 0 is ignored silently.
- A CDB write to a tag out of range, or to an entry that is FREE or already DONE, is ignored and sets cdb_err. cdb_err clears only on reset.

Commit:
- commit_valid = (entry[head] state == DONE).
- Commit fields come from entry[head] and read as zero when commit_valid is low.
- On commit_valid && commit_ready: the entry becomes FREE and head increments.
- At most one retirement per cycle.
- Clearing the RAT mapping (only if it still holds commit_tag) is the consumer's job.
- rd = 0 retires normally; the ARF discards the write.

Counting:
- rob_count is +1 on allocation, -1 on commit, unchanged when both occur in the same cycle.
- alloc_ready = (rob_count != ROB_DEPTH).

## Timing
- Reset values:
  - All entries FREE; head = tail = 0; rob_count = 0.
  - alloc_ready = 1, alloc_tag = 1.
  - commit_valid = 0; commit_tag, commit_type, commit_rd, commit_value = 0.
  - cdb_err = 0.
- Reset asserted mid-operation discards every entry immediately; a handshake in flight is lost.
- Allocate at edge N: the entry is ISSUED from N; alloc_tag advances in the same edge.
- CDB at edge N: the entry is DONE after N. If it is the head, commit_valid rises in the cycle following N. There is no CDB-to-commit bypass (minimum one cycle).
- Full ROB: alloc_ready is 0 even when a commit occurs in that cycle. There is no same-cycle reuse of a freed slot; alloc_ready rises the cycle after the commit.
- Empty ROB: commit_valid = 0 and alloc_tag = head+1.
- Allocate, CDB and commit may all occur in one cycle on distinct entries, and all take effect.
- A CDB write targeting the entry being allocated in the same cycle cannot occur legally, because that entry is FREE; it is flagged as an error.
- commit_valid held with commit_ready low keeps every commit output stable.

## Structure
- Shared package tomasulo_pkg:
  - instruction type localparams (LOAD/ADD/SUB/MUL/DIV);
  - the entry state enum (FREE/ISSUED/DONE);
  - the rob_entry_t struct (state, type, rd, value);
  - the ROB_DEPTH/TAG_W defaults;
  - a wrap-increment function shared with decode.
- No sub-module: the entry array, the pointer logic and the count live in rob_commit.

## Test plan
- Reset, then 8 allocations (ADD rd=3..10) -> tags 1..8 returned, rob_count=8, alloc_ready=0; a 9th alloc_valid is ignored.
- Allocate tags 1,2; CDB tag 2 value 0x55, then tag 1 value 0x11 -> commit_valid stays 0 until tag 1 is DONE; then retires tag1/0x11 followed by tag2/0x55, in order.
- Head DONE with commit_ready=0 for 3 cycles -> outputs stable, rob_count unchanged; commit_ready=1 -> one retirement, head advances.
- Fill the ROB, then commit 3, allocate 3 -> tags 1,2,3 reissued after wrap; alloc_tag sequence after 8 is 1.
- CDB tag 5 while entry 5 is FREE, then tag 12 -> both ignored, cdb_err=1 and held until rst_n low.
- Full ROB with head DONE: commit and alloc_valid in the same cycle -> commit happens, alloc is refused, alloc_ready=1 on the next cycle.
